// File: rtl/ndt_transmitter.sv
// ----------------------------------------------------------------------------
// ndt_transmitter
//   Builds NDT words for the network side. Host words arrive on a valid/ready
//   handshake. Words flagged with tx_soft_error are discarded and counted. The
//   surviving words get a wrapping sequence tag and are buffered in a small
//   FIFO. Each buffered word is presented as {data, tag} with the tag in the
//   LSBs.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   tx_valid      : host word present
//   tx_data       : host data word
//   tx_soft_error : host word is corrupt and is dropped on accept
//   tx_ready      : transmitter can accept a word this cycle
//   ndt_out       : {data, tag} of the head entry, or zero when empty
//   ndt_valid     : ndt_out holds a buffered word
//   ndt_ready     : network consumes ndt_out this cycle
//   fifo_count    : number of buffered words
//   drop_count    : soft-error drops since reset, saturating at 255
// ----------------------------------------------------------------------------
module ndt_transmitter #(
   parameter int unsigned data_size  = 32,
   parameter int unsigned tag_size   = 8,
   parameter int unsigned fifo_depth = 4,
   localparam int unsigned ptr_w     = $clog2(fifo_depth),
   localparam int unsigned cnt_w     = ptr_w + 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_valid,
   input  logic [data_size-1:0]          tx_data,
   input  logic                          tx_soft_error,
   output logic                          tx_ready,
   output logic [data_size+tag_size-1:0] ndt_out,
   output logic                          ndt_valid,
   input  logic                          ndt_ready,
   output logic [cnt_w-1:0]              fifo_count,
   output logic [7:0]                    drop_count
);

   localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_depth);

   logic [data_size+tag_size-1:0] mem_q [fifo_depth];
   logic [ptr_w-1:0]              head_q, head_d;
   logic [ptr_w-1:0]              tail_q, tail_d;
   logic [cnt_w-1:0]              count_q, count_d;
   logic [tag_size-1:0]           tag_q, tag_d;
   logic [7:0]                    drop_q, drop_d;

   logic accept, push, drop, pop;

   // Ready is a function of registered occupancy only, so no combinational
   // path exists from tx_valid or ndt_ready.
   assign tx_ready   = (count_q != full_count);
   assign ndt_valid  = (count_q != '0);
   assign ndt_out    = ndt_valid ? mem_q[head_q] : '0;
   assign fifo_count = count_q;
   assign drop_count = drop_q;

   assign accept = tx_valid & tx_ready;
   assign push   = accept & ~tx_soft_error;
   assign drop   = accept & tx_soft_error;
   assign pop    = ndt_valid & ndt_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      tag_d   = tag_q;
      drop_d  = drop_q;

      if (push) begin
         tail_d = tail_q + ptr_w'(1);
         tag_d  = tag_q + tag_size'(1);
      end
      if (pop) begin
         head_d = head_q + ptr_w'(1);
      end
      if (push && !pop) begin
         count_d = count_q + cnt_w'(1);
      end else if (!push && pop) begin
         count_d = count_q - cnt_w'(1);
      end
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         tag_q   <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         tag_q   <= tag_d;
         drop_q  <= drop_d;
      end
   end

   // Storage needs no reset: it is only visible through ndt_out, which is
   // masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail_q] <= {tx_data, tag_q};
      end
   end

endmodule

// File: tb/tb_ndt_transmitter.sv
module tb_ndt_transmitter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tx_valid = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_soft_error = 1'b0;
   logic        tx_ready;
   logic [39:0] ndt_out;
   logic        ndt_valid;
   logic        ndt_ready = 1'b0;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue of NDT words, a tag counter and a drop counter.
   logic [39:0] mq[$];
   int          m_tag;
   int          m_drops;

   always #5 clk = ~clk;

   ndt_transmitter #(
      .data_size (32),
      .tag_size  (8),
      .fifo_depth(DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_soft_error(tx_soft_error),
      .tx_ready     (tx_ready),
      .ndt_out      (ndt_out),
      .ndt_valid    (ndt_valid),
      .ndt_ready    (ndt_ready),
      .fifo_count   (fifo_count),
      .drop_count   (drop_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_tag   = 0;
      m_drops = 0;
   endtask

   // Compare DUT outputs to the model, then advance model and DUT one edge.
   task automatic apply(input logic v, input logic [31:0] d, input logic se, input logic rdy);
      bit          e_ready, e_valid;
      logic [39:0] e_out;
      tx_valid      = v;
      tx_data       = d;
      tx_soft_error = se;
      ndt_ready     = rdy;
      e_ready = (mq.size() != DEPTH);
      e_valid = (mq.size() != 0);
      e_out   = e_valid ? mq[0] : 40'h0;
      check("m_tx_ready", 64'(tx_ready), 64'(e_ready));
      check("m_ndt_valid", 64'(ndt_valid), 64'(e_valid));
      check("m_ndt_out", 64'(ndt_out), 64'(e_out));
      check("m_fifo_count", 64'(fifo_count), 64'(mq.size()));
      check("m_drop_count", 64'(drop_count), 64'(m_drops));
      if (e_valid && rdy) void'(mq.pop_front());
      if (v && e_ready) begin
         if (se) begin
            if (m_drops < 255) m_drops++;
         end else begin
            mq.push_back({d, 8'(m_tag)});
            m_tag = (m_tag + 1) % 256;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit          rst;
      logic        v;
      logic [31:0] d;
      logic        se;
      logic        rdy;
      logic        e_ready;
      logic        e_valid;
      logic [39:0] e_out;
      logic [2:0]  e_cnt;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t vec[21];

   initial begin
      // Expected columns describe outputs before the row's inputs are clocked.
      vec[0]  = '{1, 1, 32'hDEADBEEF, 0, 1, 1, 0, 40'h0, 3'd0, 8'd0};
      vec[1]  = '{0, 0, 32'h0,        0, 1, 1, 1, 40'hDEADBEEF_00, 3'd1, 8'd0};
      vec[2]  = '{0, 0, 32'h0,        0, 1, 1, 0, 40'h0, 3'd0, 8'd0};
      vec[3]  = '{1, 1, 32'h11111111, 0, 0, 1, 0, 40'h0, 3'd0, 8'd0};
      vec[4]  = '{0, 1, 32'h22222222, 1, 0, 1, 1, 40'h11111111_00, 3'd1, 8'd0};
      vec[5]  = '{0, 1, 32'h33333333, 0, 0, 1, 1, 40'h11111111_00, 3'd1, 8'd1};
      vec[6]  = '{0, 0, 32'h0,        0, 1, 1, 1, 40'h11111111_00, 3'd2, 8'd1};
      vec[7]  = '{0, 0, 32'h0,        0, 1, 1, 1, 40'h33333333_01, 3'd1, 8'd1};
      vec[8]  = '{0, 0, 32'h0,        0, 0, 1, 0, 40'h0, 3'd0, 8'd1};
      vec[9]  = '{1, 1, 32'hA0000000, 0, 0, 1, 0, 40'h0, 3'd0, 8'd0};
      vec[10] = '{0, 1, 32'hA1111111, 0, 0, 1, 1, 40'hA0000000_00, 3'd1, 8'd0};
      vec[11] = '{0, 1, 32'hA2222222, 0, 0, 1, 1, 40'hA0000000_00, 3'd2, 8'd0};
      vec[12] = '{0, 1, 32'hA3333333, 0, 0, 1, 1, 40'hA0000000_00, 3'd3, 8'd0};
      vec[13] = '{0, 1, 32'hA4444444, 0, 0, 0, 1, 40'hA0000000_00, 3'd4, 8'd0};
      vec[14] = '{0, 1, 32'hA4444444, 0, 1, 0, 1, 40'hA0000000_00, 3'd4, 8'd0};
      vec[15] = '{0, 1, 32'hA4444444, 0, 0, 1, 1, 40'hA1111111_01, 3'd3, 8'd0};
      vec[16] = '{0, 0, 32'h0,        0, 1, 0, 1, 40'hA1111111_01, 3'd4, 8'd0};
      vec[17] = '{0, 0, 32'h0,        0, 1, 1, 1, 40'hA2222222_02, 3'd3, 8'd0};
      vec[18] = '{0, 0, 32'h0,        0, 1, 1, 1, 40'hA3333333_03, 3'd2, 8'd0};
      vec[19] = '{0, 0, 32'h0,        0, 1, 1, 1, 40'hA4444444_04, 3'd1, 8'd0};
      vec[20] = '{0, 0, 32'h0,        0, 1, 1, 0, 40'h0, 3'd0, 8'd0};

      model_reset();
      #12;
      check("reset_valid", 64'(ndt_valid), 64'(0));
      check("reset_out", 64'(ndt_out), 64'(0));
      check("reset_count", 64'(fifo_count), 64'(0));
      check("reset_drop", 64'(drop_count), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("reset_ready", 64'(tx_ready), 64'(1));

      // Directed table: single word, soft-error drop, full/hold behaviour.
      for (int i = 0; i < 21; i++) begin
         if (vec[i].rst) do_reset();
         check($sformatf("v%0d_ready", i), 64'(tx_ready), 64'(vec[i].e_ready));
         check($sformatf("v%0d_valid", i), 64'(ndt_valid), 64'(vec[i].e_valid));
         check($sformatf("v%0d_out", i), 64'(ndt_out), 64'(vec[i].e_out));
         check($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vec[i].e_cnt));
         check($sformatf("v%0d_drop", i), 64'(drop_count), 64'(vec[i].e_drop));
         apply(vec[i].v, vec[i].d, vec[i].se, vec[i].rdy);
      end

      // Tag wrap: 260 good words streamed straight through.
      do_reset();
      for (int i = 0; i < 260; i++) begin
         if (i == 256) check("wrap_pending_tag", 64'(ndt_out[7:0]), 64'(8'hFF));
         apply(1'b1, 32'(i), 1'b0, 1'b1);
         if (i == 256) check("wrap_tag_zero", 64'(ndt_out), 64'({32'(256), 8'h00}));
      end
      for (int i = 0; i < 3; i++) apply(1'b0, 32'h0, 1'b0, 1'b1);

      // Drop saturation: 300 soft-error words never reach the output.
      for (int i = 0; i < 300; i++) begin
         apply(1'b1, $urandom, 1'b1, 1'(i % 2));
         if (ndt_valid !== 1'b0) check("drop_no_valid", 64'(ndt_valid), 64'(0));
      end
      check("drop_saturated", 64'(drop_count), 64'(255));

      // Asynchronous reset with three words buffered.
      do_reset();
      apply(1'b1, 32'h01010101, 1'b0, 1'b0);
      apply(1'b1, 32'h02020202, 1'b0, 1'b0);
      apply(1'b1, 32'h03030303, 1'b0, 1'b0);
      tx_valid = 1'b0;
      check("pre_async_count", 64'(fifo_count), 64'(3));
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", 64'(ndt_valid), 64'(0));
      check("async_count", 64'(fifo_count), 64'(0));
      check("async_out", 64'(ndt_out), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      apply(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
      check("post_reset_tag", 64'(ndt_out), 64'(40'hCAFEF00D_00));

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         apply(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
